// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor: multi-cycle a - b - bin, DIGIT bits per clock, LSD first, start/busy/done handshake.
// Optional signed overflow flag `ovf` when SUB_SIGNED_OVF_EN is defined.
module digit_serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SUB_SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d, res_nx;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, bout_q, bout_d, done_q, done_d, last;
   logic [DIGIT:0]   dsub;
`ifdef SUB_SIGNED_OVF_EN
   logic             as_q, as_d, bs_q, bs_d, ovf_q, ovf_d;
`endif
   // One DIGIT+1-bit subtract; the top bit is the outgoing borrow.
   assign dsub = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, br_q};
   assign last = cnt_q == CW'(N - 1);
   generate
      if (DIGIT == WIDTH) begin : g_one
         assign res_nx = dsub[DIGIT-1:0];
      end else begin : g_many
         assign res_nx = {dsub[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
      end
   endgenerate
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      done_d  = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      as_d    = as_q;
      bs_d    = bs_q;
      ovf_d   = ovf_q;
`endif
      if (state_q == IDLE) begin
         if (start) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            br_d    = bin;
            cnt_d   = '0;
`ifdef SUB_SIGNED_OVF_EN
            as_d    = a[WIDTH-1];
            bs_d    = b[WIDTH-1];
`endif
         end
      end else begin
         a_d   = a_q >> DIGIT;
         b_d   = b_q >> DIGIT;
         res_d = res_nx;
         br_d  = dsub[DIGIT];
         cnt_d = last ? '0 : cnt_q + 1'b1;
         if (last) begin
            state_d = IDLE;
            diff_d  = res_nx;
            bout_d  = dsub[DIGIT];
            done_d  = 1'b1;
`ifdef SUB_SIGNED_OVF_EN
            ovf_d   = (as_q != bs_q) && (res_nx[WIDTH-1] != as_q);
`endif
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
         as_q    <= 1'b0;
         bs_q    <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         done_q  <= done_d;
`ifdef SUB_SIGNED_OVF_EN
         as_q    <= as_d;
         bs_q    <= bs_d;
         ovf_q   <= ovf_d;
`endif
      end
   end
   assign busy = state_q == RUN;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SUB_SIGNED_OVF_EN
   assign ovf  = ovf_q;
`endif
endmodule
